// File: rtl/tv80_arb_pkg.sv
// Shared types and sizing helpers for the TV80 test-memory arbiter.
package tv80_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE
  } arb_state_e;

  localparam int unsigned DEF_AW        = 16;
  localparam int unsigned DEF_DW        = 8;
  localparam int unsigned DEF_MAX_BURST = 16;
  localparam int unsigned DEF_GAP       = 4;
  localparam int unsigned DEF_ACK_TMO   = 64;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tv80_mem_arbiter.sv
// Shares the single-port test memory between the TV80 core and a DMA requester,
// taking the bus through BUSRQ_n/BUSAK_n with a burst limit and a CPU dwell gap.
module tv80_mem_arbiter
  import tv80_arb_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST,
  parameter int unsigned GAP       = DEF_GAP,
  parameter int unsigned ACK_TMO   = DEF_ACK_TMO
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cpu_mreq_n,
  input  logic          i_cpu_rd_n,
  input  logic          i_cpu_wr_n,
  input  logic          i_cpu_rfsh_n,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_dout,
  output logic [DW-1:0] o_cpu_din,
  output logic          o_cpu_busrq_n,
  input  logic          i_cpu_busak_n,
  input  logic          i_dma_req,
  output logic          o_dma_gnt,
  input  logic          i_dma_valid,
  input  logic          i_dma_we,
  input  logic          i_dma_last,
  input  logic [AW-1:0] i_dma_addr,
  input  logic [DW-1:0] i_dma_wdata,
  output logic [DW-1:0] o_dma_rdata,
  output logic          o_dma_rvalid,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  output logic          o_mem_re,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_err
);

  localparam int unsigned BW = cnt_w(MAX_BURST);
  localparam int unsigned GW = cnt_w(GAP + 1);
  localparam int unsigned TW = cnt_w(ACK_TMO);

  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TMO - 1);

  arb_state_e    r_state;
  arb_state_e    w_next;
  logic [BW-1:0] r_beat_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_busrq_n;
  logic          r_gnt;
  logic          r_rvalid;
  logic          r_err;
  logic          w_beat;
  logic          w_set_err;
  logic          w_enter_req;

  assign w_beat      = r_gnt & i_dma_valid;
  assign w_enter_req = (r_state != REQ) && (w_next == REQ);

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_dma_req && (r_gap_cnt == '0)) w_next = REQ;
      end
      REQ: begin
        if (!i_cpu_busak_n) begin
          w_next = GRANT;
        end else if (!i_dma_req) begin
          w_next = RELEASE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_next    = RELEASE;
          w_set_err = 1'b1;
        end
      end
      GRANT: begin
        // Last beat and burst limit together still give a single release.
        if ((w_beat && (i_dma_last || (r_beat_cnt == BEAT_LAST))) || !i_dma_req)
          w_next = RELEASE;
      end
      RELEASE: begin
        if (i_cpu_busak_n) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs follow the next state so they change on the transition edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busrq_n <= 1'b1;
      r_gnt     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_busrq_n <= !((w_next == REQ) || (w_next == GRANT));
      r_gnt     <= (w_next == GRANT);
      r_rvalid  <= w_beat & ~i_dma_we;
      r_err     <= r_err | w_set_err;
    end
  end

  // Beat, ack-timeout and CPU dwell counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      if (w_enter_req)  r_beat_cnt <= '0;
      else if (w_beat)  r_beat_cnt <= r_beat_cnt + BW'(1);

      if (w_enter_req)           r_tmo_cnt <= '0;
      else if (r_state == REQ)   r_tmo_cnt <= r_tmo_cnt + TW'(1);

      if ((r_state == RELEASE) && (w_next == IDLE))
        r_gap_cnt <= GAP_LOAD;
      else if ((r_state == IDLE) && (r_gap_cnt != '0))
        r_gap_cnt <= r_gap_cnt - GW'(1);
    end
  end

  // Memory port mux; CPU strobes are dropped while the DMA holds the grant.
  always_comb begin
    if (r_gnt) begin
      o_mem_addr  = i_dma_addr;
      o_mem_wdata = i_dma_wdata;
      o_mem_we    = i_dma_valid & i_dma_we;
      o_mem_re    = i_dma_valid & ~i_dma_we;
    end else begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_dout;
      o_mem_we    = ~i_cpu_mreq_n & ~i_cpu_wr_n & i_cpu_rfsh_n;
      o_mem_re    = ~i_cpu_mreq_n & ~i_cpu_rd_n;
    end
  end

  assign o_cpu_din     = i_mem_rdata;
  assign o_dma_rdata   = i_mem_rdata;
  assign o_cpu_busrq_n = r_busrq_n;
  assign o_dma_gnt     = r_gnt;
  assign o_dma_rvalid  = r_rvalid;
  assign o_err         = r_err;

endmodule

// File: tb/tb_tv80_mem_arbiter.sv
// Randomized bench for tv80_mem_arbiter: memory/CPU models plus a transaction-level
// reference (reference memory image, read-return queue, per-grant beat budget).
module tb_tv80_mem_arbiter;

  localparam int unsigned MAXB = 16;
  localparam int unsigned GAP  = 4;
  localparam int unsigned TMO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_mreq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1, cpu_rfsh_n = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        busrq_n;
  logic        busak_n = 1'b1;
  logic        dma_req = 1'b0, dma_valid = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        dma_gnt;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = '0;
  logic        err;

  tv80_mem_arbiter #(.AW(16), .DW(8), .MAX_BURST(MAXB), .GAP(GAP), .ACK_TMO(TMO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cpu_mreq_n(cpu_mreq_n), .i_cpu_rd_n(cpu_rd_n), .i_cpu_wr_n(cpu_wr_n),
    .i_cpu_rfsh_n(cpu_rfsh_n), .i_cpu_addr(cpu_addr), .i_cpu_dout(cpu_dout),
    .o_cpu_din(cpu_din), .o_cpu_busrq_n(busrq_n), .i_cpu_busak_n(busak_n),
    .i_dma_req(dma_req), .o_dma_gnt(dma_gnt), .i_dma_valid(dma_valid),
    .i_dma_we(dma_we), .i_dma_last(dma_last), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .o_mem_re(mem_re), .i_mem_rdata(mem_rdata), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Synchronous single-port RAM, one-cycle read latency.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  // CPU bus-acknowledge model: ack after ack_dly cycles of BUSRQ_n low; negative = never.
  int ack_dly = 0;
  int ack_cnt = 0;
  always @(negedge clk) begin
    if (busrq_n) begin
      busak_n = 1'b1;
      ack_cnt = 0;
    end else if (ack_dly >= 0) begin
      if (ack_cnt >= ack_dly) busak_n = 1'b0;
      else ack_cnt++;
    end
  end

  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_t;

  rd_t        rq[$];
  rd_t        rd_tmp;
  logic [7:0] dq[$];
  bit         mon_en = 1'b0;
  bit         prev_gnt = 1'b0;
  bit         rel_pend = 1'b0;
  int         cyc = 0, gbeats = 0, gexp = 0, xfer_rem = 0, hi_run = 0;
  int         rv_cnt = 0, n_grants = 0;
  logic       m_re, m_we, m_rv;
  logic [15:0] m_addr;
  logic [7:0]  m_wd;

  // Reference monitor, sampled late in each cycle once inputs have settled.
  always @(negedge clk) begin
    #4;
    if (mon_en && !rst) begin
      cyc++;
      m_rv = (rq.size() != 0) && (rq[0].due == cyc);
      chk("rvalid", dma_rvalid, m_rv);
      if (m_rv) begin
        chk("rdata", dma_rdata, rq[0].data);
        rd_tmp = rq.pop_front();
        rv_cnt++;
      end
      if (dma_gnt) begin
        m_re = dma_valid & ~dma_we;   m_we = dma_valid & dma_we;
        m_addr = dma_addr;            m_wd = dma_wdata;
      end else begin
        m_re = ~cpu_mreq_n & ~cpu_rd_n;
        m_we = ~cpu_mreq_n & ~cpu_wr_n & cpu_rfsh_n;
        m_addr = cpu_addr;            m_wd = cpu_dout;
      end
      chk("mem_re", mem_re, m_re);
      chk("mem_we", mem_we, m_we);
      if (m_re || m_we) chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wd);
      chk("cpu_din", cpu_din, mem_rdata);
      if (dma_gnt) chk("busrq_in_gnt", busrq_n, 0);

      if (dma_gnt && !prev_gnt) begin
        n_grants++;
        gbeats = 0;
        gexp = (xfer_rem < int'(MAXB)) ? xfer_rem : int'(MAXB);
      end
      if (!dma_gnt && prev_gnt) begin
        chk("burst_len", gbeats, gexp);
        rel_pend = 1'b1;
      end
      if (busrq_n) hi_run++;
      else begin
        if (rel_pend) chk("cpu_gap", hi_run >= int'(GAP + 1), 1);
        rel_pend = 1'b0;
        hi_run = 0;
      end

      if (m_we) ref_mem[m_addr] = m_wd;
      if (dma_gnt && dma_valid) begin
        gbeats++;
        xfer_rem--;
        if (!dma_we) begin
          rd_tmp.due  = cyc + 1;
          rd_tmp.data = ref_mem[dma_addr];
          rq.push_back(rd_tmp);
        end
      end
      prev_gnt = dma_gnt;
    end
  end

  task automatic cpu_idle();
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_rfsh_n = 1'b1;
  endtask

  // One DMA transfer of n beats; wmode 0=read, 1=write, 2=mixed.
  task automatic dma_xfer(input int n, input logic [15:0] base, input int wmode,
                          input bit dense, input bit quiet);
    int idx = 0;
    int guard = 0;
    @(negedge clk);
    xfer_rem = n;
    dma_req = 1'b1;
    while (idx < n && guard < 3000) begin
      if (dma_gnt && (dense || $urandom_range(3) != 0)) begin
        dma_valid = 1'b1;
        dma_addr  = base + 16'(idx);
        dma_we    = (wmode == 2) ? 1'($urandom_range(1)) : 1'(wmode);
        dma_wdata = (dq.size() != 0) ? dq.pop_front() : 8'($urandom);
        dma_last  = (idx == n - 1);
        idx++;
      end else begin
        dma_valid = dma_gnt ? 1'b0 : 1'($urandom_range(1));
        dma_we    = 1'b1;
        dma_last  = 1'($urandom_range(1));
        dma_addr  = 16'($urandom_range(255));
        dma_wdata = 8'($urandom);
      end
      if (quiet) cpu_idle();
      else begin
        cpu_addr   = 16'($urandom_range(255));
        cpu_dout   = 8'($urandom);
        cpu_mreq_n = 1'($urandom_range(1));
        cpu_rd_n   = 1'($urandom_range(1));
        cpu_wr_n   = 1'($urandom_range(1));
        cpu_rfsh_n = 1'($urandom_range(1));
      end
      @(negedge clk);
      guard++;
    end
    chk("xfer_done", idx, n);
    dma_req = 1'b0; dma_valid = 1'b0; dma_last = 1'b0;
    cpu_idle();
  endtask

  int reqc, guard, nmis, rv0, g0;
  bit sawg;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[0] = 8'h5A;
    ref_mem[0] = 8'h5A;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busrq", busrq_n, 1);
    chk("rst_gnt", dma_gnt, 0);
    chk("rst_rvalid", dma_rvalid, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle CPU read of address 0.
    @(negedge clk);
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 16'h0000;
    #1;
    chk("cpu_rd_re", mem_re, 1);
    chk("cpu_rd_addr", mem_addr, 16'h0000);
    chk("cpu_rd_busrq", busrq_n, 1);
    @(posedge clk); #1;
    chk("cpu_rd_din", cpu_din, 8'h5A);
    @(negedge clk);
    cpu_idle();

    // Refresh cycle suppresses the CPU write.
    @(negedge clk);
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; cpu_rfsh_n = 1'b0; cpu_addr = 16'h0010; cpu_dout = 8'hC3;
    #1 chk("rfsh_we", mem_we, 0);
    cpu_rfsh_n = 1'b1;
    #1 chk("cpu_wr_we", mem_we, 1);
    @(negedge clk);
    cpu_idle();
    @(negedge clk);
    chk("cpu_wr_mem", mem[16'h0010], 8'hC3);

    // Four-beat DMA write, CPU acks after 3 cycles.
    ack_dly = 3;
    dq = '{8'h12, 8'h34, 8'h56, 8'h78};
    dma_xfer(4, 16'h0000, 1, 1'b1, 1'b1);
    chk("w4_gnt_drop", dma_gnt, 0);
    repeat (8) @(negedge clk);
    chk("w4_mem0", mem[0], 8'h12);
    chk("w4_mem1", mem[1], 8'h34);
    chk("w4_mem2", mem[2], 8'h56);
    chk("w4_mem3", mem[3], 8'h78);
    chk("w4_idle_busrq", busrq_n, 1);

    // 20-beat read split by the burst limit.
    ack_dly = 2;
    rv0 = rv_cnt;
    g0 = n_grants;
    dma_xfer(20, 16'h0040, 0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("r20_rvalid_cnt", rv_cnt - rv0, 20);
    chk("r20_grants", n_grants - g0, 2);

    // Random transfers with random ack latency and CPU traffic.
    for (int t = 0; t < 30; t++) begin
      ack_dly = $urandom_range(5);
      dma_xfer($urandom_range(40, 1), 16'($urandom_range(200)), $urandom_range(2),
               1'($urandom_range(1)), 1'b0);
      repeat ($urandom_range(10, 1)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    nmis = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("mem_image", nmis, 0);
    chk("no_err", err, 0);
    chk("rq_drained", rq.size(), 0);

    // CPU never acknowledges.
    ack_dly = -1;
    @(negedge clk);
    dma_req = 1'b1;
    reqc = 0; sawg = 1'b0; guard = 0;
    while (!err && guard < 300) begin
      @(negedge clk);
      guard++;
      if (!busrq_n) reqc++;
      if (dma_gnt) sawg = 1'b1;
    end
    dma_req = 1'b0;
    chk("tmo_cycles", reqc, TMO);
    chk("tmo_err", err, 1);
    chk("tmo_busrq", busrq_n, 1);
    chk("tmo_no_gnt", sawg, 0);
    repeat (10) @(negedge clk);
    chk("tmo_err_sticky", err, 1);

    // Asynchronous reset in the middle of a grant.
    ack_dly = 0;
    xfer_rem = 1;
    @(negedge clk);
    dma_req = 1'b1;
    guard = 0;
    while (!dma_gnt && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("arst_gnt_seen", dma_gnt, 1);
    dma_valid = 1'b1; dma_we = 1'b0; dma_last = 1'b0; dma_addr = 16'h0020;
    @(posedge clk); #2;
    chk("arst_pre_rvalid", dma_rvalid, 1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_busrq", busrq_n, 1);
    chk("arst_gnt", dma_gnt, 0);
    chk("arst_rvalid", dma_rvalid, 0);
    chk("arst_err", err, 0);
    dma_req = 1'b0; dma_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rq.delete();
    prev_gnt = 1'b0; rel_pend = 1'b0; hi_run = 0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_idle_busrq", busrq_n, 1);
    chk("arst_idle_gnt", dma_gnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
